// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_ctrl_pkg
//  Description : Shared definitions for the AES round-control logic:
//                scheduler state encoding, round counts for the three AES
//                key sizes, and the round-key index mapping.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

    // Round counts for AES-128 / AES-192 / AES-256.
    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // Scheduler states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Round-key index used in round r.
    // Encryption walks the keys upward. Decryption walks them downward,
    // starting from key NR.
    // The same mapping covers the initial load (r = 0) and the final
    // round (r = NR).
    function automatic int key_index(input logic dec, input int r, input int nr);
        return dec ? (nr - r) : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_sched.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_sched
//  Description : Iterative AES round scheduler. Accepts one 128-bit block at
//                a time and sequences a shared round datapath through NR
//                rounds. After the last round it holds the result valid
//                until the consumer takes it.
//  Ports       : clk, rst          - clock, async active-high reset
//                key_ready         - round keys 0..NR present in key store
//                in_valid/in_ready - block input handshake
//                in_decrypt        - 1 = decrypt, sampled on accept
//                abort             - synchronous cancel of the current block
//                out_valid/out_ready - result handshake
//                dp_load/dp_en/dp_final/dp_inv/dp_round - datapath controls
//                key_idx           - round-key index for this cycle
//                busy              - block in flight
//  Parameters  : NR - rounds per block (10/12/14).
//                RW - width of the round and key-index fields.
//                     Requires 2**RW > NR.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_sched
    import aes_ctrl_pkg::*;
#(
    parameter int NR = NR_128,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_ready,
    input  logic          in_valid,
    input  logic          in_decrypt,
    output logic          in_ready,
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          dp_load,
    output logic          dp_en,
    output logic          dp_final,
    output logic          dp_inv,
    output logic [RW-1:0] dp_round,
    output logic [RW-1:0] key_idx,
    output logic          busy
);

    localparam logic [RW-1:0] C_NR    = RW'(NR);
    localparam logic [RW-1:0] C_NR_M1 = RW'(NR - 1);
    localparam logic [RW-1:0] C_ONE   = RW'(1);

    state_e        state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic          dec_q, dec_d;

    logic          w_accept;
    logic [RW-1:0] w_kidx_run;
    logic [RW-1:0] w_kidx_idle;

    // The accept term is masked with rst. While reset is held, dp_load and
    // dp_inv stay low even if a block is being presented.
    assign w_accept = (state_q == ST_IDLE) & in_valid & key_ready & ~abort & ~rst;

    // The round counter already holds NR in FINAL, so one mapping serves
    // ROUND and FINAL.
    assign w_kidx_run  = RW'(key_index(dec_q, int'(r_q), NR));
    assign w_kidx_idle = RW'(key_index(in_decrypt, 0, NR));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            dec_q   <= dec_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        dec_d   = dec_q;
        if (abort) begin
            // Cancel wins over every other event, in every state.
            state_d = ST_IDLE;
            r_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        dec_d   = in_decrypt;
                        r_d     = C_ONE;
                        state_d = (NR == 1) ? ST_FINAL : ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (r_q == C_NR_M1) begin
                        r_d     = C_NR;
                        state_d = ST_FINAL;
                    end else begin
                        r_d     = r_q + C_ONE;
                    end
                end
                ST_FINAL: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        r_d     = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    r_d     = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dp_load   = 1'b0;
        dp_en     = 1'b0;
        dp_final  = 1'b0;
        dp_inv    = 1'b0;
        dp_round  = '0;
        key_idx   = '0;
        busy      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                // While reset is held, in_ready follows key_ready and
                // ignores abort.
                in_ready = key_ready & (rst | ~abort);
                dp_load  = w_accept;
                dp_inv   = in_decrypt & w_accept;
                key_idx  = w_kidx_idle;
            end
            ST_ROUND: begin
                dp_en    = ~abort;
                dp_round = r_q;
                dp_inv   = dec_q;
                key_idx  = w_kidx_run;
            end
            ST_FINAL: begin
                dp_en    = ~abort;
                dp_final = 1'b1;
                dp_round = C_NR;
                dp_inv   = dec_q;
                key_idx  = w_kidx_run;
            end
            ST_DONE: begin
                out_valid = ~abort;
                dp_inv    = dec_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire
